// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one single-port 4K x 16 RAM; one access per 3 cycles.
// Define RAM_ARBITER_FIXED_PRIO_EN to make A win every contention instead of round-robin.
module ram_arbiter #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          load_a,
    input  logic          load_b,
    input  logic [AW-1:0] address_a,
    input  logic [AW-1:0] address_b,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [DW-1:0] mem_in,
    output logic [AW-1:0] mem_address,
    output logic          mem_load,
    input  logic [DW-1:0] mem_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    logic   owner_b;
    logic   load_q;
    logic   grant_b;

`ifdef RAM_ARBITER_FIXED_PRIO_EN
    assign grant_b = req_b & ~req_a;
`else
    // last_b set means B was granted last, so A takes the next contention
    logic last_b;
    assign grant_b = req_b & (~req_a | ~last_b);
`endif

    // Write strobe is gated by reset so an aborted access never reaches the RAM
    assign mem_load = load_q & (state == ACCESS) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            mem_address <= '0;
            mem_in      <= '0;
            load_q      <= 1'b0;
            owner_b     <= 1'b0;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
            last_b      <= 1'b1;
`endif
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a | req_b) begin
                        owner_b     <= grant_b;
                        load_q      <= grant_b ? load_b    : load_a;
                        mem_address <= grant_b ? address_b : address_a;
                        mem_in      <= grant_b ? in_b      : in_a;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!load_q) begin
                        if (owner_b) out_b <= mem_out;
                        else         out_a <= mem_out;
                    end
                    ack_a <= ~owner_b;
                    ack_b <= owner_b;
                    state <= DONE;
                end
                DONE: begin
`ifndef RAM_ARBITER_FIXED_PRIO_EN
                    last_b <= owner_b;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 4K x 16 RAM (sync write, async read).
module tb_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        req_a, req_b, load_a, load_b;
    logic [11:0] address_a, address_b;
    logic [15:0] in_a, in_b;
    logic        ack_a, ack_b;
    logic [15:0] out_a, out_b;
    logic [15:0] mem_in;
    logic [11:0] mem_address;
    logic        mem_load;
    logic [15:0] mem_out;

    logic [15:0] mem [4096];

    typedef struct {
        logic        b;
        logic [15:0] a_val;
        logic [15:0] b_val;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ml_cnt   = 0;
    bit   spacing_en = 0;
    bit   have_prev  = 0;
    int   prev_ack   = 0;

    ram_arbiter dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b), .load_a(load_a), .load_b(load_b),
        .address_a(address_a), .address_b(address_b), .in_a(in_a), .in_b(in_b),
        .ack_a(ack_a), .ack_b(ack_b), .out_a(out_a), .out_b(out_b),
        .mem_in(mem_in), .mem_address(mem_address), .mem_load(mem_load),
        .mem_out(mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    always @(posedge clk) if (mem_load) mem[mem_address] <= mem_in;
    assign mem_out = mem[mem_address];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per ack pulse
    always @(negedge clk) begin
        exp_t e;
        if (mem_load) ml_cnt++;
        if (ack_a && ack_b) chk("ack_exclusive", 32'd1, 32'd0);
        if (ack_a || ack_b) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=a%0b/b%0b required=none", ack_a, ack_b);
            end else begin
                e = q.pop_front();
                chk("ack_owner_b", 32'(ack_b), 32'(e.b));
                chk("out_a", 32'(out_a), 32'(e.a_val));
                chk("out_b", 32'(out_b), 32'(e.b_val));
                chk("mem_load_in_done", 32'(mem_load), 32'd0);
            end
            if (spacing_en && have_prev) chk("ack_spacing", 32'(cyc - prev_ack), 32'd3);
            prev_ack  = cyc;
            have_prev = spacing_en;
        end
    end

    task automatic wait_ack(input logic port_b);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (port_b ? ack_b : ack_a) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout actual=none required=ack_%s", port_b ? "b" : "a");
        end
        @(posedge clk);
        #1;
        if (port_b) req_b = 1'b0;
        else        req_a = 1'b0;
    endtask

    task automatic drive(input logic port_b, input logic ld, input logic [11:0] addr,
                         input logic [15:0] data);
        if (port_b) begin
            req_b = 1'b1; load_b = ld; address_b = addr; in_b = data;
        end else begin
            req_a = 1'b1; load_a = ld; address_a = addr; in_a = data;
        end
    endtask

    task automatic access(input logic port_b, input logic ld, input logic [11:0] addr,
                          input logic [15:0] data, input logic [15:0] ea, input logic [15:0] eb);
        int ml0;
        q.push_back('{port_b, ea, eb});
        ml0 = ml_cnt;
        drive(port_b, ld, addr, data);
        wait_ack(port_b);
        chk("mem_load_cycles", 32'(ml_cnt - ml0), 32'(ld));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int acks;
        reset = 1'b1;
        req_a = 0; req_b = 0; load_a = 0; load_b = 0;
        address_a = '0; address_b = '0; in_a = '0; in_b = '0;

        // Reset values
        @(negedge clk);
        chk("rst_ack_a", 32'(ack_a), 32'd0);
        chk("rst_ack_b", 32'(ack_b), 32'd0);
        chk("rst_out_a", 32'(out_a), 32'd0);
        chk("rst_out_b", 32'(out_b), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_in", 32'(mem_in), 32'd0);
        chk("rst_mem_load", 32'(mem_load), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Write then read on A
        access(1'b0, 1'b1, 12'h123, 16'hBEEF, 16'h0000, 16'h0000);
        access(1'b0, 1'b0, 12'h123, 16'h0000, 16'hBEEF, 16'h0000);
        // Port isolation at the top address
        access(1'b1, 1'b1, 12'hFFF, 16'h0055, 16'hBEEF, 16'h0000);
        access(1'b0, 1'b0, 12'hFFF, 16'h0000, 16'h0055, 16'h0000);
        access(1'b0, 1'b1, 12'h001, 16'hAAAA, 16'h0055, 16'h0000);
        access(1'b1, 1'b1, 12'h002, 16'h5555, 16'h0055, 16'h0000);

        // Address change while the read of 0x001 is in flight
        q.push_back('{1'b0, 16'hAAAA, 16'h0000});
        drive(1'b0, 1'b0, 12'h001, 16'h0000);
        @(posedge clk);
        #1;
        address_a = 12'h002;
        @(negedge clk);
        chk("inflight_mem_address", 32'(mem_address), 32'h001);
        wait_ack(1'b0);

        access(1'b1, 1'b0, 12'h002, 16'h0000, 16'hAAAA, 16'h5555);
        access(1'b0, 1'b1, 12'h010, 16'h0F0F, 16'hAAAA, 16'h5555);

        // Reset during the ACCESS cycle of a write: dropped, no ack
        drive(1'b0, 1'b1, 12'h010, 16'h1234);
        @(posedge clk);
        #1;
        reset = 1'b1;
        req_a = 1'b0;
        @(negedge clk);
        chk("rst_access_mem_load", 32'(mem_load), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_out_a", 32'(out_a), 32'd0);
        chk("post_rst_out_b", 32'(out_b), 32'd0);
        access(1'b0, 1'b0, 12'h010, 16'h0000, 16'h0F0F, 16'h0000);

        // Sustained contention after reset
        do_reset();
`ifdef RAM_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) q.push_back('{1'b0, 16'hBEEF, 16'h0000});
`else
        q.push_back('{1'b0, 16'hBEEF, 16'h0000});
        q.push_back('{1'b1, 16'hBEEF, 16'h0055});
        q.push_back('{1'b0, 16'hBEEF, 16'h0055});
        q.push_back('{1'b1, 16'hBEEF, 16'h0055});
`endif
        spacing_en = 1;
        have_prev  = 0;
        drive(1'b0, 1'b0, 12'h123, 16'h0000);
        drive(1'b1, 1'b0, 12'hFFF, 16'h0000);
        acks = 0;
        for (int i = 0; i < 40 && acks < 4; i++) begin
            @(negedge clk);
            if (ack_a || ack_b) acks++;
        end
        chk("contention_acks", 32'(acks), 32'd4);
        @(posedge clk);
        #1;
        req_a = 1'b0;
        req_b = 1'b0;
        spacing_en = 0;
        repeat (5) @(posedge clk);
        #1;

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
